scalu_rs: RTL and testbench
===========================

// Module: scalu_rs
// PURPOSE
// - Reservation station and issue scheduler for the single-cycle scalar ALU (scalu).
// - Holds dispatched ALU ops until both operands are available, captures results from the writeback bus,
//   and issues the oldest ready op per cycle on the exers_scalu_* interface, honouring scalu_stall and rob_flush.
// - Sits between dispatch/rename and scalu.
// PARAMETERS
// - DEPTH  4  number of RS entries (power of two, 2..8)
// PORTS
// - clk                 in   1   single clock, all state on posedge
// - rst                 in   1   asynchronous, active-low reset (0 = reset)
// - disp_valid          in   1   dispatch request
// - disp_op             in   5   scalu opcode
// - disp_robid          in   7   ROB id
// - disp_rd             in   6   destination tag
// - disp_op1_rdy/op2_rdy in  1   operand already available
// - disp_op1_tag/op2_tag in  6   producer tag when not ready
// - disp_op1/op2        in   32  operand value when ready
// - rs_stall            out  1   RS full; dispatch must hold
// - wb_valid            in   1   writeback broadcast valid
// - wb_rd               in   6   writeback tag
// - wb_result           in   32  writeback value
// - exers_scalu_issue   out  1   issue valid to scalu
// - exers_scalu_op      out  5   issued opcode
// - exers_robid         out  7   issued ROB id
// - exers_rd            out  6   issued dest tag
// - exers_op1/op2       out  32  issued operand values
// - scalu_stall         in   1   scalu cannot accept this cycle
// - rob_flush           in   1   squash all in-flight ops
// BEHAVIOUR
// - Reset (rst=0, async): all entry valid bits and age state cleared; rs_stall=0, exers_scalu_issue=0.
//   Payload registers are not reset; other issue outputs are don't-care while exers_scalu_issue=0.
// - Entry state: valid, op, robid, rd, per operand {rdy, tag, value}, plus an age matrix (older[i][j]).
// - Dispatch: accepted when disp_valid & ~rs_stall & ~rob_flush; written to lowest-index free entry;
//   marked younger than every currently valid entry.
// - rs_stall = all DEPTH entries valid (registered state only; a same-cycle issue does not free a slot).
// - Wakeup: wb_valid with wb_rd == tag of a not-ready operand sets rdy and captures wb_result next edge.
//   Also applies to an op dispatched in the same cycle (dispatch-time bypass): both operands may wake at once.
// - Select: combinational over registered state; candidate = valid & op1_rdy & op2_rdy;
//   the oldest candidate (age matrix) drives exers_*; exers_scalu_issue = any candidate & ~rob_flush.
// - Issue handshake: entry is freed at the edge where exers_scalu_issue & ~scalu_stall; otherwise it
//   stays and outputs hold (same entry remains oldest; outputs stable while scalu_stall=1).
// - Latency: op dispatched with both operands ready at edge t issues in cycle t+1 (earliest).
//   Wakeup at edge t -> issue in cycle t+1. No same-cycle wakeup-to-issue bypass.
// - Simultaneous events: dispatch into a slot and issue-free of another slot in one cycle both take effect;
//   wakeup of an entry being issued is irrelevant (its operands are already ready).
// - rob_flush: all valid bits cleared at next edge, dispatch ignored, exers_scalu_issue forced 0 that cycle;
//   has priority over dispatch, wakeup and issue.
// - Reset asserted mid-operation: immediate clear regardless of stall/flush; no issue until after release.
// STRUCTURE
// - Shared package: scalu opcode constants (ADD/SUB, SLL, SLT, SLTU, XOR/SEQ, SRL/SRA, OR, AND encodings),
//   ROBID_W=7, TAG_W=6, XLEN=32, RS entry struct typedef.
// - One sub-module: scalu_rs_select -- DEPTH-entry age matrix + oldest-ready one-hot picker
//   (inputs: ready vector, alloc one-hot, free one-hot, flush; output: grant one-hot).
// - Top holds entry storage, free-slot priority encoder, tag comparators, output mux.
// TESTING
// - Ready dispatch: op=ADD, op1=5, op2=7, both rdy at edge t, scalu_stall=0 -> issue=1 in cycle t+1 with
//   op1=5, op2=7, robid/rd echoed; issue=0 in t+2.
// - Wakeup: dispatch op1_tag=12 not ready -> no issue; wb_valid, wb_rd=12, wb_result=0xDEAD at edge t ->
//   issue in t+1 with op1=0xDEAD; wb_rd=13 instead -> never issues.
// - Age order: dispatch A(robid 3, waiting), B(robid 4, ready), C(robid 5, ready) -> B then C issue;
//   wake A -> A issues before any later-dispatched ready op.
// - Stall/full: scalu_stall=1, dispatch 4 ready ops -> rs_stall=1 after 4th, exers_* held constant;
//   release stall -> one issue per cycle in dispatch order, rs_stall=0 one cycle after first issue.
// - Flush: 3 valid entries, rob_flush=1 with disp_valid=1 -> issue=0 that cycle, RS empty next cycle, dispatched op dropped.
// - Async reset: drop rst to 0 mid-cycle with entries valid -> exers_scalu_issue=0 and rs_stall=0
//   immediately, before next clk edge.

Source files
------------

// File: rtl/scalu_rs_pkg.sv
// Shared types and constants for the scalar ALU reservation station.
package scalu_rs_pkg;

  localparam int unsigned XLEN    = 32;
  localparam int unsigned TAG_W   = 6;
  localparam int unsigned ROBID_W = 7;
  localparam int unsigned OP_W    = 5;

  localparam logic [OP_W-1:0] OP_ADD  = 5'd0;
  localparam logic [OP_W-1:0] OP_SUB  = 5'd1;
  localparam logic [OP_W-1:0] OP_SLL  = 5'd2;
  localparam logic [OP_W-1:0] OP_SLT  = 5'd3;
  localparam logic [OP_W-1:0] OP_SLTU = 5'd4;
  localparam logic [OP_W-1:0] OP_XOR  = 5'd5;
  localparam logic [OP_W-1:0] OP_SEQ  = 5'd6;
  localparam logic [OP_W-1:0] OP_SRL  = 5'd7;
  localparam logic [OP_W-1:0] OP_SRA  = 5'd8;
  localparam logic [OP_W-1:0] OP_OR   = 5'd9;
  localparam logic [OP_W-1:0] OP_AND  = 5'd10;

  typedef struct packed {
    logic [OP_W-1:0]    op;
    logic [ROBID_W-1:0] robid;
    logic [TAG_W-1:0]   rd;
    logic               op1_rdy;
    logic [TAG_W-1:0]   op1_tag;
    logic [XLEN-1:0]    op1;
    logic               op2_rdy;
    logic [TAG_W-1:0]   op2_tag;
    logic [XLEN-1:0]    op2;
  } rs_entry_t;

endpackage

// File: rtl/scalu_rs_if.sv
// Dispatch, writeback, issue and control signals between rename, the RS and scalu.
interface scalu_rs_if;
  import scalu_rs_pkg::*;

  logic                disp_valid;
  logic [OP_W-1:0]     disp_op;
  logic [ROBID_W-1:0]  disp_robid;
  logic [TAG_W-1:0]    disp_rd;
  logic                disp_op1_rdy;
  logic                disp_op2_rdy;
  logic [TAG_W-1:0]    disp_op1_tag;
  logic [TAG_W-1:0]    disp_op2_tag;
  logic [XLEN-1:0]     disp_op1;
  logic [XLEN-1:0]     disp_op2;
  logic                rs_stall;
  logic                wb_valid;
  logic [TAG_W-1:0]    wb_rd;
  logic [XLEN-1:0]     wb_result;
  logic                exers_scalu_issue;
  logic [OP_W-1:0]     exers_scalu_op;
  logic [ROBID_W-1:0]  exers_robid;
  logic [TAG_W-1:0]    exers_rd;
  logic [XLEN-1:0]     exers_op1;
  logic [XLEN-1:0]     exers_op2;
  logic                scalu_stall;
  logic                rob_flush;

  modport master (
    output disp_valid, disp_op, disp_robid, disp_rd, disp_op1_rdy, disp_op2_rdy,
           disp_op1_tag, disp_op2_tag, disp_op1, disp_op2,
           wb_valid, wb_rd, wb_result, scalu_stall, rob_flush,
    input  rs_stall, exers_scalu_issue, exers_scalu_op, exers_robid, exers_rd,
           exers_op1, exers_op2
  );

  modport slave (
    input  disp_valid, disp_op, disp_robid, disp_rd, disp_op1_rdy, disp_op2_rdy,
           disp_op1_tag, disp_op2_tag, disp_op1, disp_op2,
           wb_valid, wb_rd, wb_result, scalu_stall, rob_flush,
    output rs_stall, exers_scalu_issue, exers_scalu_op, exers_robid, exers_rd,
           exers_op1, exers_op2
  );

endinterface

// File: rtl/scalu_rs_select.sv
// Age matrix plus oldest-ready picker: older[i][j] = 1 when entry i was allocated before entry j.
module scalu_rs_select #(
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [DEPTH-1:0] ready,
  input  logic [DEPTH-1:0] alloc,
  input  logic [DEPTH-1:0] free,
  input  logic             flush,
  output logic [DEPTH-1:0] grant
);

  logic [DEPTH-1:0][DEPTH-1:0] older;

  // New entry clears its row (older than nobody) and sets its column (everyone is older).
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      older <= '0;
    end else if (flush) begin
      older <= '0;
    end else begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        for (int unsigned j = 0; j < DEPTH; j++) begin
          if (alloc[i])                older[i][j] <= 1'b0;
          else if (alloc[j] && i != j) older[i][j] <= 1'b1;
          else if (free[j])            older[i][j] <= 1'b0;
        end
      end
    end
  end

  always_comb begin
    grant = ready;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      for (int unsigned j = 0; j < DEPTH; j++) begin
        if (ready[j] && older[j][i]) grant[i] = 1'b0;
      end
    end
  end

endmodule

// File: rtl/scalu_rs.sv
// Reservation station for scalu: holds ops until operands arrive, issues the oldest ready op each cycle.
module scalu_rs
  import scalu_rs_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  scalu_rs_if.slave  bus
);

  logic [DEPTH-1:0] valid;
  logic [DEPTH-1:0] ready;
  logic [DEPTH-1:0] alloc_oh;
  logic [DEPTH-1:0] free_oh;
  logic [DEPTH-1:0] grant;
  rs_entry_t        ent [DEPTH];
  rs_entry_t        disp_ent;
  logic             full;
  logic             disp_fire;
  logic             issue_fire;
  logic             found;

  assign full      = &valid;
  assign disp_fire = bus.disp_valid & ~full & ~bus.rob_flush;

  always_comb begin
    alloc_oh = '0;
    found    = 1'b0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (!valid[i] && !found) begin
        alloc_oh[i] = disp_fire;
        found       = 1'b1;
      end
    end
  end

  // Dispatch-time bypass: an operand produced on this cycle's writeback is captured on entry.
  always_comb begin
    disp_ent.op      = bus.disp_op;
    disp_ent.robid   = bus.disp_robid;
    disp_ent.rd      = bus.disp_rd;
    disp_ent.op1_tag = bus.disp_op1_tag;
    disp_ent.op2_tag = bus.disp_op2_tag;
    disp_ent.op1_rdy = bus.disp_op1_rdy | (bus.wb_valid && bus.wb_rd == bus.disp_op1_tag);
    disp_ent.op2_rdy = bus.disp_op2_rdy | (bus.wb_valid && bus.wb_rd == bus.disp_op2_tag);
    disp_ent.op1     = bus.disp_op1_rdy ? bus.disp_op1 : bus.wb_result;
    disp_ent.op2     = bus.disp_op2_rdy ? bus.disp_op2 : bus.wb_result;
  end

  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (alloc_oh[i]) begin
        ent[i] <= disp_ent;
      end else begin
        if (!ent[i].op1_rdy && bus.wb_valid && bus.wb_rd == ent[i].op1_tag) begin
          ent[i].op1_rdy <= 1'b1;
          ent[i].op1     <= bus.wb_result;
        end
        if (!ent[i].op2_rdy && bus.wb_valid && bus.wb_rd == ent[i].op2_tag) begin
          ent[i].op2_rdy <= 1'b1;
          ent[i].op2     <= bus.wb_result;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)               valid <= '0;
    else if (bus.rob_flush) valid <= '0;
    else                    valid <= (valid & ~free_oh) | alloc_oh;
  end

  always_comb begin
    for (int unsigned i = 0; i < DEPTH; i++) begin
      ready[i] = valid[i] & ent[i].op1_rdy & ent[i].op2_rdy;
    end
  end

  scalu_rs_select #(.DEPTH(DEPTH)) u_select (
    .clk   (clk),
    .rst   (rst),
    .ready (ready),
    .alloc (alloc_oh),
    .free  (free_oh),
    .flush (bus.rob_flush),
    .grant (grant)
  );

  assign bus.exers_scalu_issue = (|ready) & ~bus.rob_flush;
  assign issue_fire            = bus.exers_scalu_issue & ~bus.scalu_stall;
  assign free_oh               = grant & {DEPTH{issue_fire}};
  assign bus.rs_stall          = full;

  always_comb begin
    bus.exers_scalu_op = '0;
    bus.exers_robid    = '0;
    bus.exers_rd       = '0;
    bus.exers_op1      = '0;
    bus.exers_op2      = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (grant[i]) begin
        bus.exers_scalu_op = ent[i].op;
        bus.exers_robid    = ent[i].robid;
        bus.exers_rd       = ent[i].rd;
        bus.exers_op1      = ent[i].op1;
        bus.exers_op2      = ent[i].op2;
      end
    end
  end

endmodule

// File: tb/tb_scalu_rs.sv
// Scoreboard bench for scalu_rs: directed dispatch/wakeup/stall/flush/reset vectors.
module tb_scalu_rs;
  import scalu_rs_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   cyc = 0;
  int   n_pass = 0;
  int   n_total = 0;

  typedef struct {
    logic [4:0]  op;
    logic [6:0]  robid;
    logic [5:0]  rd;
    logic [31:0] op1;
    logic [31:0] op2;
    int          cyc;
  } exp_t;

  exp_t sb[$];

  scalu_rs_if bus ();

  scalu_rs #(.DEPTH(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_total++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %0h required %0h (t=%0t)", nm, act, req, $time);
  endtask

  task automatic push(input logic [4:0] op, input logic [6:0] robid, input logic [5:0] rd,
                      input logic [31:0] v1, input logic [31:0] v2, input int c);
    exp_t e;
    e.op = op; e.robid = robid; e.rd = rd; e.op1 = v1; e.op2 = v2; e.cyc = c;
    sb.push_back(e);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic disp(input logic [4:0] op, input logic [6:0] robid, input logic [5:0] rd,
                      input logic r1, input logic [5:0] t1, input logic [31:0] v1,
                      input logic r2, input logic [5:0] t2, input logic [31:0] v2);
    bus.disp_valid   = 1'b1;
    bus.disp_op      = op;
    bus.disp_robid   = robid;
    bus.disp_rd      = rd;
    bus.disp_op1_rdy = r1;
    bus.disp_op1_tag = t1;
    bus.disp_op1     = v1;
    bus.disp_op2_rdy = r2;
    bus.disp_op2_tag = t2;
    bus.disp_op2     = v2;
    step();
    bus.disp_valid   = 1'b0;
  endtask

  // Monitor: every accepted issue must match the head of the scoreboard.
  always @(negedge clk) begin
    if (rst && bus.exers_scalu_issue && !bus.scalu_stall) begin
      if (sb.size() == 0) begin
        n_total++;
        $display("FAIL unexpected_issue: got robid %0d, required no issue (t=%0t)", bus.exers_robid, $time);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("issue_op",    32'(bus.exers_scalu_op), 32'(e.op));
        chk("issue_robid", 32'(bus.exers_robid),    32'(e.robid));
        chk("issue_rd",    32'(bus.exers_rd),       32'(e.rd));
        chk("issue_op1",   bus.exers_op1,           e.op1);
        chk("issue_op2",   bus.exers_op2,           e.op2);
        if (e.cyc >= 0) chk("issue_cycle", 32'(cyc), 32'(e.cyc));
      end
    end
  end

  initial begin
    bus.disp_valid = 1'b0; bus.disp_op = '0; bus.disp_robid = '0; bus.disp_rd = '0;
    bus.disp_op1_rdy = 1'b0; bus.disp_op2_rdy = 1'b0; bus.disp_op1_tag = '0; bus.disp_op2_tag = '0;
    bus.disp_op1 = '0; bus.disp_op2 = '0;
    bus.wb_valid = 1'b0; bus.wb_rd = '0; bus.wb_result = '0;
    bus.scalu_stall = 1'b0; bus.rob_flush = 1'b0;

    #2;
    chk("reset_rs_stall", 32'(bus.rs_stall), 32'd0);
    chk("reset_issue",    32'(bus.exers_scalu_issue), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;

    // Ready dispatch: issues in the cycle right after the dispatch edge, gone the cycle after.
    disp(OP_ADD, 7'd1, 6'd10, 1'b1, 6'd0, 32'd5, 1'b1, 6'd0, 32'd7);
    push(OP_ADD, 7'd1, 6'd10, 32'd5, 32'd7, cyc);
    step();
    @(negedge clk);
    chk("ready_issue_gone", 32'(bus.exers_scalu_issue), 32'd0);
    step();

    // Wakeup: wrong tag never wakes, matching tag issues next cycle with the broadcast value.
    disp(OP_ADD, 7'd2, 6'd11, 1'b0, 6'd12, 32'd0, 1'b1, 6'd0, 32'd3);
    @(negedge clk);
    chk("wait_no_issue", 32'(bus.exers_scalu_issue), 32'd0);
    step();
    bus.wb_valid = 1'b1; bus.wb_rd = 6'd13; bus.wb_result = 32'hBEEF;
    step();
    bus.wb_valid = 1'b0;
    repeat (2) step();
    chk("wrong_tag_no_issue", 32'(bus.exers_scalu_issue), 32'd0);
    bus.wb_valid = 1'b1; bus.wb_rd = 6'd12; bus.wb_result = 32'hDEAD;
    step();
    push(OP_ADD, 7'd2, 6'd11, 32'hDEAD, 32'd3, cyc);
    bus.wb_valid = 1'b0;
    repeat (2) step();

    // Age order: B, C issue while A waits; woken A beats later ready D.
    push(OP_SLT,  7'd4, 6'd21, 32'd4, 32'd40, -1);
    push(OP_SLTU, 7'd5, 6'd22, 32'd5, 32'd50, -1);
    push(OP_SLL,  7'd3, 6'd20, 32'h20, 32'd2, -1);
    push(OP_SRA,  7'd6, 6'd23, 32'd6, 32'd60, -1);
    disp(OP_SLL,  7'd3, 6'd20, 1'b0, 6'd20, 32'd0, 1'b1, 6'd0, 32'd2);
    disp(OP_SLT,  7'd4, 6'd21, 1'b1, 6'd0, 32'd4, 1'b1, 6'd0, 32'd40);
    disp(OP_SLTU, 7'd5, 6'd22, 1'b1, 6'd0, 32'd5, 1'b1, 6'd0, 32'd50);
    bus.wb_valid = 1'b1; bus.wb_rd = 6'd20; bus.wb_result = 32'h20;
    disp(OP_SRA,  7'd6, 6'd23, 1'b1, 6'd0, 32'd6, 1'b1, 6'd0, 32'd60);
    bus.wb_valid = 1'b0;
    repeat (3) step();

    // Stall/full: outputs hold, a dispatch into a full RS is dropped, then drain in order.
    bus.scalu_stall = 1'b1;
    push(OP_SUB, 7'd8,  6'd30, 32'd100,  32'd1,    -1);
    push(OP_XOR, 7'd9,  6'd31, 32'hF0,   32'h0F,   -1);
    push(OP_AND, 7'd10, 6'd32, 32'hFF00, 32'h0FF0, -1);
    push(OP_OR,  7'd11, 6'd33, 32'h1,    32'h2,    -1);
    disp(OP_SUB, 7'd8,  6'd30, 1'b1, 6'd0, 32'd100,  1'b1, 6'd0, 32'd1);
    disp(OP_XOR, 7'd9,  6'd31, 1'b1, 6'd0, 32'hF0,   1'b1, 6'd0, 32'h0F);
    disp(OP_AND, 7'd10, 6'd32, 1'b1, 6'd0, 32'hFF00, 1'b1, 6'd0, 32'h0FF0);
    chk("three_not_full", 32'(bus.rs_stall), 32'd0);
    disp(OP_OR,  7'd11, 6'd33, 1'b1, 6'd0, 32'h1,    1'b1, 6'd0, 32'h2);
    chk("four_full", 32'(bus.rs_stall), 32'd1);
    @(negedge clk);
    chk("stall_issue_valid", 32'(bus.exers_scalu_issue), 32'd1);
    chk("stall_hold_robid1", 32'(bus.exers_robid), 32'd8);
    step();
    disp(OP_SEQ, 7'd12, 6'd34, 1'b1, 6'd0, 32'd9, 1'b1, 6'd0, 32'd9);
    @(negedge clk);
    chk("stall_hold_robid2", 32'(bus.exers_robid), 32'd8);
    chk("stall_hold_op1",    bus.exers_op1, 32'd100);
    step();
    bus.scalu_stall = 1'b0;
    @(negedge clk);
    chk("full_before_free", 32'(bus.rs_stall), 32'd1);
    step();
    chk("not_full_after_free", 32'(bus.rs_stall), 32'd0);
    repeat (5) step();

    // Flush: held entries and the same-cycle dispatch are all discarded.
    bus.scalu_stall = 1'b1;
    disp(OP_ADD, 7'd20, 6'd1, 1'b1, 6'd0, 32'd1, 1'b1, 6'd0, 32'd1);
    disp(OP_ADD, 7'd21, 6'd2, 1'b1, 6'd0, 32'd2, 1'b1, 6'd0, 32'd2);
    disp(OP_ADD, 7'd22, 6'd3, 1'b1, 6'd0, 32'd3, 1'b1, 6'd0, 32'd3);
    bus.rob_flush = 1'b1;
    bus.scalu_stall = 1'b0;
    bus.disp_valid = 1'b1; bus.disp_robid = 7'd23; bus.disp_op1_rdy = 1'b1; bus.disp_op2_rdy = 1'b1;
    @(negedge clk);
    chk("flush_issue_forced0", 32'(bus.exers_scalu_issue), 32'd0);
    step();
    bus.rob_flush = 1'b0; bus.disp_valid = 1'b0;
    chk("flush_empty_issue", 32'(bus.exers_scalu_issue), 32'd0);
    chk("flush_empty_stall", 32'(bus.rs_stall), 32'd0);
    repeat (2) step();

    // Async reset mid-cycle with a full RS.
    bus.scalu_stall = 1'b1;
    disp(OP_AND, 7'd40, 6'd4, 1'b1, 6'd0, 32'd1, 1'b1, 6'd0, 32'd1);
    disp(OP_AND, 7'd41, 6'd5, 1'b1, 6'd0, 32'd1, 1'b1, 6'd0, 32'd1);
    disp(OP_AND, 7'd42, 6'd6, 1'b1, 6'd0, 32'd1, 1'b1, 6'd0, 32'd1);
    disp(OP_AND, 7'd43, 6'd7, 1'b1, 6'd0, 32'd1, 1'b1, 6'd0, 32'd1);
    chk("pre_reset_issue", 32'(bus.exers_scalu_issue), 32'd1);
    chk("pre_reset_full",  32'(bus.rs_stall), 32'd1);
    #2 rst = 1'b0;
    #1;
    chk("async_reset_issue", 32'(bus.exers_scalu_issue), 32'd0);
    chk("async_reset_stall", 32'(bus.rs_stall), 32'd0);
    step();
    rst = 1'b1;
    bus.scalu_stall = 1'b0;
    repeat (2) step();
    chk("post_reset_issue", 32'(bus.exers_scalu_issue), 32'd0);

    chk("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
